// File: rtl/counter_pkg.sv
// Shared constants for the parametrised up/down counter family:
// SATURATE mode selectors and encodings of the up (direction) input.
package counter_pkg;

  localparam int   CNT_WRAP = 0;
  localparam int   CNT_SAT  = 1;

  localparam logic DIR_UP   = 1'b1;
  localparam logic DIR_DOWN = 1'b0;

endpackage

// File: rtl/updown_counter_next.sv
// Combinational next-state logic for updown_counter_param: load clamp,
// up/down step, end-of-range wrap or saturate, and the terminal-count flag.
module updown_counter_next
  import counter_pkg::*;
#(
  parameter int WIDTH    = 4,
  parameter int MAX_VAL  = 2**WIDTH-1,
  parameter int SATURATE = CNT_WRAP
) (
  input  logic [WIDTH-1:0] q,
  input  logic             up,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  output logic [WIDTH-1:0] next_q,
  output logic             wrap_evt,
  output logic             sat_evt,
  output logic             tc
);

  localparam logic [WIDTH-1:0] MAX_Q = WIDTH'(MAX_VAL);
  localparam logic [WIDTH-1:0] ONE   = {{(WIDTH-1){1'b0}}, 1'b1};

  logic at_top;
  logic at_bottom;

  assign at_top    = (q == MAX_Q);
  assign at_bottom = (q == '0);
  assign tc        = (up == DIR_UP) ? at_top : at_bottom;

  // next_q is what q becomes when the top lets this cycle through (load or en).
  always_comb begin
    next_q   = q;
    wrap_evt = 1'b0;
    sat_evt  = 1'b0;
    if (load) begin
      next_q = (load_val > MAX_Q) ? MAX_Q : load_val;
    end else if (up == DIR_UP) begin
      if (!at_top) begin
        next_q = q + ONE;
      end else if (SATURATE == CNT_SAT) begin
        sat_evt = 1'b1;
      end else begin
        next_q   = '0;
        wrap_evt = 1'b1;
      end
    end else begin
      if (!at_bottom) begin
        next_q = q - ONE;
      end else if (SATURATE == CNT_SAT) begin
        sat_evt = 1'b1;
      end else begin
        next_q   = MAX_Q;
        wrap_evt = 1'b1;
      end
    end
  end

endmodule

// File: rtl/updown_counter_param.sv
// Parametrised synchronous up/down counter with load, wrap/saturate mode and
// registered wrap/sat status. Priority per edge: reset > load > en > hold.
module updown_counter_param
  import counter_pkg::*;
#(
  parameter int WIDTH     = 4,
  parameter int MAX_VAL   = 2**WIDTH-1,
  parameter int RESET_VAL = 0,
  parameter int SATURATE  = CNT_WRAP
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             en,
  input  logic             up,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  output logic [WIDTH-1:0] q,
  output logic             tc,
  output logic             wrap,
  output logic             sat
);

  if (WIDTH < 2 || MAX_VAL < 1 || MAX_VAL > (2**WIDTH)-1 ||
      RESET_VAL < 0 || RESET_VAL > MAX_VAL) begin : g_bad_params
    $fatal(1, "updown_counter_param: illegal WIDTH/MAX_VAL/RESET_VAL combination");
  end

  localparam logic [WIDTH-1:0] RST_Q = WIDTH'(RESET_VAL);

  logic [WIDTH-1:0] next_q;
  logic             wrap_evt;
  logic             sat_evt;

  updown_counter_next #(
    .WIDTH    (WIDTH),
    .MAX_VAL  (MAX_VAL),
    .SATURATE (SATURATE)
  ) u_next (
    .q        (q),
    .up       (up),
    .load     (load),
    .load_val (load_val),
    .next_q   (next_q),
    .wrap_evt (wrap_evt),
    .sat_evt  (sat_evt),
    .tc       (tc)
  );

  // On hold cycles sat keeps its value so a parked saturated counter stays flagged.
  always_ff @(posedge clk) begin
    if (reset) begin
      q    <= RST_Q;
      wrap <= 1'b0;
      sat  <= 1'b0;
    end else if (load || en) begin
      q    <= next_q;
      wrap <= wrap_evt;
      sat  <= sat_evt;
    end else begin
      wrap <= 1'b0;
    end
  end

endmodule

// File: tb/tb_updown_counter_param.sv
// Bench for updown_counter_param: three configurations share one stimulus
// stream and are scored against an integer reference model.
module tb_updown_counter_param;

  localparam int W  = 4;
  localparam int NI = 3;

  // Instance configurations: default wrap, mod-10 wrap, mod-10 saturate.
  localparam int MX [NI] = '{15, 9, 9};
  localparam int RV [NI] = '{0, 0, 3};
  localparam int SM [NI] = '{0, 0, 1};

  logic         clk = 1'b0;
  logic         reset = 1'b0;
  logic         en = 1'b0;
  logic         up = 1'b0;
  logic         load = 1'b0;
  logic [W-1:0] load_val = '0;

  wire  [W-1:0] q_a [NI];
  wire  [NI-1:0] tc_a;
  wire  [NI-1:0] wrap_a;
  wire  [NI-1:0] sat_a;

  int checks = 0;
  int errors = 0;

  logic [W-1:0] exp_q [$];
  int  m_q    [NI];
  bit  m_wrap [NI];
  bit  m_sat  [NI];
  bit  m_valid = 1'b0;

  // clock / reset block
  always #5 clk = ~clk;

  updown_counter_param #(.WIDTH(W), .MAX_VAL(15), .RESET_VAL(0), .SATURATE(0)) dut0 (
    .clk(clk), .reset(reset), .en(en), .up(up), .load(load), .load_val(load_val),
    .q(q_a[0]), .tc(tc_a[0]), .wrap(wrap_a[0]), .sat(sat_a[0]));

  updown_counter_param #(.WIDTH(W), .MAX_VAL(9), .RESET_VAL(0), .SATURATE(0)) dut1 (
    .clk(clk), .reset(reset), .en(en), .up(up), .load(load), .load_val(load_val),
    .q(q_a[1]), .tc(tc_a[1]), .wrap(wrap_a[1]), .sat(sat_a[1]));

  updown_counter_param #(.WIDTH(W), .MAX_VAL(9), .RESET_VAL(3), .SATURATE(1)) dut2 (
    .clk(clk), .reset(reset), .en(en), .up(up), .load(load), .load_val(load_val),
    .q(q_a[2]), .tc(tc_a[2]), .wrap(wrap_a[2]), .sat(sat_a[2]));

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  function automatic bit model_tc(input int i, input bit u);
    return (u && m_q[i] == MX[i]) || (!u && m_q[i] == 0);
  endfunction

  // Advance the reference model by one clock using the current inputs.
  task automatic model_step();
    for (int i = 0; i < NI; i++) begin
      if (reset) begin
        m_q[i] = RV[i]; m_wrap[i] = 1'b0; m_sat[i] = 1'b0;
      end else if (load) begin
        m_q[i] = (int'(load_val) > MX[i]) ? MX[i] : int'(load_val);
        m_wrap[i] = 1'b0; m_sat[i] = 1'b0;
      end else if (en) begin
        int n;
        n = up ? m_q[i] + 1 : m_q[i] - 1;
        m_wrap[i] = 1'b0;
        if (n < 0 || n > MX[i]) begin
          if (SM[i] != 0) m_sat[i] = 1'b1;
          else begin
            m_q[i] = up ? 0 : MX[i];
            m_wrap[i] = 1'b1;
          end
        end else begin
          m_q[i] = n;
          m_sat[i] = 1'b0;
        end
      end else begin
        m_wrap[i] = 1'b0;
      end
      exp_q.push_back(W'(m_q[i]));
    end
    m_valid = 1'b1;
  endtask

  // driver: apply one cycle of inputs, check tc combinationally, then the edge results.
  task automatic drive(input bit r, input bit l, input logic [W-1:0] lv, input bit e, input bit u);
    @(negedge clk);
    reset = r; load = l; load_val = lv; en = e; up = u;
    #1;
    if (m_valid)
      for (int i = 0; i < NI; i++) check($sformatf("tc_pre[%0d]", i), tc_a[i], model_tc(i, u));
    model_step();
    @(posedge clk);
    #1;
    for (int i = 0; i < NI; i++) begin
      logic [W-1:0] e_q;
      e_q = exp_q.pop_front();
      check($sformatf("q[%0d]", i), q_a[i], e_q);
      check($sformatf("wrap[%0d]", i), wrap_a[i], m_wrap[i]);
      check($sformatf("sat[%0d]", i), sat_a[i], m_sat[i]);
      check($sformatf("tc[%0d]", i), tc_a[i], model_tc(i, up));
    end
  endtask

  initial begin
    // reset then count down through the 0 -> MAX wrap
    drive(1, 0, 0, 0, 0);
    for (int k = 0; k < 18; k++) drive(0, 0, 0, 1, 0);
    // count up from 0 through the mod-10 wrap
    drive(1, 0, 0, 0, 1);
    drive(0, 1, 0, 0, 1);
    for (int k = 0; k < 12; k++) drive(0, 0, 0, 1, 1);
    // saturate at top from 7, then step away
    drive(0, 1, 7, 0, 1);
    for (int k = 0; k < 5; k++) drive(0, 0, 0, 1, 1);
    drive(0, 0, 0, 1, 0);
    // load clamps and beats en, then in-range load
    drive(0, 1, 12, 1, 1);
    drive(0, 1, 5, 1, 0);
    // enable low holds; toggling up moves tc only at an end
    for (int k = 0; k < 3; k++) drive(0, 0, 0, 0, k[0]);
    drive(0, 1, 0, 0, 0);
    drive(0, 0, 0, 0, 1);
    drive(0, 0, 0, 0, 0);
    // reset beats a concurrent load, counting resumes from the reset value
    drive(0, 1, 3, 0, 1);
    drive(1, 1, 7, 1, 1);
    drive(0, 0, 0, 1, 1);
    // saturate at bottom, hold keeps sat
    drive(0, 1, 1, 0, 0);
    for (int k = 0; k < 3; k++) drive(0, 0, 0, 1, 0);
    drive(0, 0, 0, 0, 0);
    // randomized traffic
    for (int k = 0; k < 400; k++) begin
      drive($urandom_range(0, 39) == 0, $urandom_range(0, 7) == 0,
            W'($urandom_range(0, 15)), $urandom_range(0, 3) != 0,
            $urandom_range(0, 4) < 3);
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
